// File: rtl/ppa_sub_seq.sv
// ppa_sub_seq: multi-cycle wide unsigned subtractor, D = A - B = A + ~B + 1,
// one SLICE-bit chunk per clock (LSB first) through a P/G prefix slice adder.
// Ports: clk, rst_n (async active-low); in_valid/in_ready + a/b operand input;
// out_valid/out_ready + diff/borrow/zero result output.
// Option: define PPA_SUB_SAT_EN for unsigned saturation (diff=0, zero=1 on borrow).
module ppa_sub_seq #(
    parameter int W     = 64,
    parameter int SLICE = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         borrow,
    output logic         zero
);

    localparam int NSLICE = W / SLICE;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int LV     = $clog2(SLICE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    a_r;
    logic [W-1:0]    nb_r;
    logic            carry;
    logic [KW-1:0]   k;

    logic [SLICE-1:0] sa;
    logic [SLICE-1:0] sb;
    logic [SLICE-1:0] sum;
    logic [SLICE-1:0] cvec;
    logic             cout;
    logic [SLICE-1:0] gl [0:LV];
    logic [SLICE-1:0] pl [0:LV];
    logic [W-1:0]     diff_nxt;
    logic             accept;
    logic             last;
    logic             release_res;

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign accept      = in_valid && in_ready;
    assign release_res = out_valid && out_ready;
    assign last        = (k == KW'(NSLICE - 1));

    assign sa = a_r[k*SLICE +: SLICE];
    assign sb = nb_r[k*SLICE +: SLICE];

    // Kogge-Stone prefix over the slice; shifted-in lanes use G=0, P=1
    // so positions below the span pass through unchanged.
    always_comb begin
        gl[0] = sa & sb;
        pl[0] = sa ^ sb;
        for (int l = 0; l < LV; l++) begin
            gl[l+1] = gl[l] | (pl[l] & (gl[l] << (1 << l)));
            pl[l+1] = pl[l] & ~(~pl[l] << (1 << l));
        end
    end

    // cvec[i] is the carry out of bit i given the slice carry-in.
    assign cvec = gl[LV] | (pl[LV] & {SLICE{carry}});
    assign sum  = pl[0] ^ {cvec[SLICE-2:0], carry};
    assign cout = cvec[SLICE-1];

    always_comb begin
        diff_nxt = diff;
        diff_nxt[k*SLICE +: SLICE] = sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (release_res) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            nb_r   <= '0;
            carry  <= 1'b1;
            k      <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            zero   <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                a_r   <= a;
                nb_r  <= ~b;
                carry <= 1'b1;
                k     <= '0;
            end else if (state == RUN) begin
                carry <= cout;
                k     <= k + 1'b1;
                diff  <= diff_nxt;
                if (last) begin
                    borrow <= ~cout;
`ifdef PPA_SUB_SAT_EN
                    if (!cout) begin
                        diff <= '0;
                        zero <= 1'b1;
                    end else begin
                        zero <= (diff_nxt == '0);
                    end
`else
                    zero <= (diff_nxt == '0);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_ppa_sub_seq.sv
// tb_ppa_sub_seq: randomized self-checking bench for ppa_sub_seq
// against a plain-arithmetic reference of the wide subtraction.
module tb_ppa_sub_seq;

    localparam int W      = 64;
    localparam int NSLICE = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;

    int n_cmp;
    int n_bad;

    ppa_sub_seq #(.W(W), .SLICE(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: modulo difference, borrow when A < B, optional saturation.
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [W-1:0] d, output logic br,
                         output logic z);
        d  = av - bv;
        br = (av < bv);
`ifdef PPA_SUB_SAT_EN
        if (br) d = '0;
`endif
        z = (d == '0);
    endtask

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] v;
        for (int i = 0; i < NSLICE; i++) begin
            case ($urandom_range(0, 3))
                0:       v[i*16 +: 16] = 16'h0000;
                1:       v[i*16 +: 16] = 16'hFFFF;
                default: v[i*16 +: 16] = 16'($urandom);
            endcase
        end
        return v;
    endfunction

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input int hold, input bit chk_lat);
        logic [W-1:0] ed;
        logic         eb;
        logic         ez;
        int           n;
        model(av, bv, ed, eb, ez);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        chk("busy_in_ready", W'(in_ready), W'(0));
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (chk_lat) chk("latency", W'(n), W'(NSLICE));
        else chk("valid_seen", W'(out_valid), W'(1));
        chk("diff", diff, ed);
        chk("borrow", W'(borrow), W'(eb));
        chk("zero", W'(zero), W'(ez));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("hold_valid", W'(out_valid), W'(1));
            chk("hold_in_ready", W'(in_ready), W'(0));
            chk("hold_diff", diff, ed);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("rel_valid", W'(out_valid), W'(0));
        chk("rel_in_ready", W'(in_ready), W'(1));
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_diff", diff, '0);
        chk("rst_borrow", W'(borrow), W'(0));
        chk("rst_zero", W'(zero), W'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(64'd5, 64'd3, 0, 1'b1);
        run_op(64'h0000_0000_0001_0000, 64'd1, 0, 1'b1);
        run_op(64'd0, 64'd1, 0, 1'b1);
        run_op(64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 0, 1'b1);
        run_op(64'h1234_5678_9ABC_DEF0, 64'd0, 0, 1'b1);
        run_op(64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 5, 1'b1);

        // Abort mid-RUN at k==2: async reset clears the handshake at once.
        a        = 64'hFFFF_0000_FFFF_0000;
        b        = 64'h0000_FFFF_0000_FFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", W'(out_valid), W'(0));
        chk("abort_in_ready", W'(in_ready), W'(1));
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(64'd100, 64'd58, 0, 1'b1);

        for (int t = 0; t < 40; t++) begin
            logic [W-1:0] av;
            logic [W-1:0] bv;
            av = rnd_op();
            case ($urandom_range(0, 4))
                0:       bv = av;
                1:       bv = '0;
                default: bv = rnd_op();
            endcase
            run_op(av, bv, $urandom_range(0, 3), 1'b1);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
